qam_tx_sequencer: RTL and testbench

- Control sequencer for the 16-QAM raised-cosine transmit datapath.
- Generates the filter phase counter, the symbol-rate strobe for the PN sources and tap delay lines, the I/Q mux select and the IF sign control.
- Runs a start/fill/run/flush state machine so the filter is primed before output is flagged valid and drained with zero symbols on stop.
- Switches coefficient ROM banks only on symbol boundaries, so no symbol mixes coefficient sets.

---
 rtl/qam_tx_sequencer.sv | 126 ++++++++++++
 tb/tb_qam_tx_sequencer.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/qam_tx_sequencer.sv
// Sequencer for the 16-QAM raised-cosine transmit path: filter phase,
// symbol strobe, I/Q/IF controls, fill/run/flush FSM and bank switching.
module qam_tx_sequencer #(
  parameter int SPS      = 8,
  parameter int SPAN     = 16,
  parameter int PIPE_LAT = 3,
  parameter int BANK_W   = 1
) (
  input  logic                    reset,
  input  logic                    clock_5000,
  input  logic                    start,
  input  logic                    stop,
  input  logic                    bank_req,
  input  logic [BANK_W-1:0]       bank_id,
  output logic [$clog2(SPS)-1:0]  phase,
  output logic                    sym_stb,
  output logic                    iq_sel,
  output logic                    mix_neg,
  output logic                    data_en,
  output logic                    out_valid,
  output logic [BANK_W-1:0]       bank_sel,
  output logic                    bank_ack,
  output logic                    busy,
  output logic [1:0]              state
);
  localparam int PW = $clog2(SPS);
  localparam int CW = $clog2(SPAN+2);

  typedef enum logic [1:0] {IDLE = 2'd0, FILL = 2'd1, RUN = 2'd2, FLUSH = 2'd3} state_t;

  state_t          st, st_nxt;
  logic [CW-1:0]   sym_cnt, sym_cnt_nxt;
  logic            stop_pend, stop_pend_nxt;
  logic [PIPE_LAT:0] vld_pipe;
  logic            pend_flag;
  logic [BANK_W-1:0] bank_pend;
  logic            last_sym;
  logic            apply_pt;

  assign busy     = (st != IDLE);
  assign state    = st;
  assign sym_stb  = busy && (phase == PW'(SPS-1));
  assign iq_sel   = phase[0];
  assign mix_neg  = busy && !phase[1];
  assign data_en  = (st == FILL) || (st == RUN);
  assign last_sym = (sym_cnt == CW'(SPAN));
  assign out_valid = vld_pipe[PIPE_LAT];

  // Banks only change on a symbol boundary while active; in IDLE any edge will do.
  assign apply_pt = busy ? sym_stb : 1'b1;
  assign bank_ack = pend_flag && apply_pt;

  always_comb begin
    st_nxt        = st;
    sym_cnt_nxt   = sym_cnt;
    stop_pend_nxt = stop_pend;
    case (st)
      IDLE: if (start && !stop) st_nxt = FILL;
      FILL: begin
        if (stop) stop_pend_nxt = 1'b1;
        if (sym_stb) begin
          sym_cnt_nxt = sym_cnt + CW'(1);
          if (last_sym) begin
            sym_cnt_nxt   = '0;
            stop_pend_nxt = 1'b0;
            st_nxt        = (stop_pend || stop) ? FLUSH : RUN;
          end
        end
      end
      RUN: begin
        if (sym_stb && (stop_pend || stop)) begin
          st_nxt        = FLUSH;
          sym_cnt_nxt   = '0;
          stop_pend_nxt = 1'b0;
        end else if (stop) begin
          stop_pend_nxt = 1'b1;
        end
      end
      FLUSH: begin
        if (sym_stb) begin
          sym_cnt_nxt = sym_cnt + CW'(1);
          if (last_sym) begin
            sym_cnt_nxt = '0;
            st_nxt      = IDLE;
          end
        end
      end
      default: st_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock_5000 or negedge reset) begin
    if (!reset) begin
      st        <= IDLE;
      phase     <= '0;
      sym_cnt   <= '0;
      stop_pend <= 1'b0;
      vld_pipe  <= '0;
    end else begin
      st        <= st_nxt;
      phase     <= busy ? phase + PW'(1) : '0;
      sym_cnt   <= sym_cnt_nxt;
      stop_pend <= stop_pend_nxt;
      // bit 0 mirrors state==RUN; the top bit lags it by PIPE_LAT cycles
      vld_pipe  <= {vld_pipe[PIPE_LAT-1:0], st_nxt == RUN};
    end
  end

  always_ff @(posedge clock_5000 or negedge reset) begin
    if (!reset) begin
      bank_sel  <= '0;
      bank_pend <= '0;
      pend_flag <= 1'b0;
    end else begin
      if (bank_ack) bank_sel <= bank_pend;
      // a request coinciding with an apply point waits for the next one
      if (bank_req) begin
        bank_pend <= bank_id;
        pend_flag <= 1'b1;
      end else if (bank_ack) begin
        pend_flag <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_qam_tx_sequencer.sv
// Randomized + directed bench for qam_tx_sequencer against a cycle-count
// reference model (active time, segment start, run-history queue).
module tb_qam_tx_sequencer;
  localparam int SPS = 8, SPAN = 16, PIPE_LAT = 3, BANK_W = 1;
  localparam int PW = $clog2(SPS);
  localparam int SEG = (SPAN + 1) * SPS;

  logic reset, clock_5000, start, stop, bank_req;
  logic [BANK_W-1:0] bank_id, bank_sel;
  logic [PW-1:0] phase;
  logic sym_stb, iq_sel, mix_neg, data_en, out_valid, bank_ack, busy;
  logic [1:0] state;

  qam_tx_sequencer #(.SPS(SPS), .SPAN(SPAN), .PIPE_LAT(PIPE_LAT), .BANK_W(BANK_W)) dut (
    .reset(reset), .clock_5000(clock_5000), .start(start), .stop(stop),
    .bank_req(bank_req), .bank_id(bank_id), .phase(phase), .sym_stb(sym_stb),
    .iq_sel(iq_sel), .mix_neg(mix_neg), .data_en(data_en), .out_valid(out_valid),
    .bank_sel(bank_sel), .bank_ack(bank_ack), .busy(busy), .state(state)
  );

  initial clock_5000 = 1'b0;
  always #5 clock_5000 = ~clock_5000;

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0h want %0h", tag, $time, got, exp);
    end
  endtask

  // Reference model: 0=IDLE 1=FILL 2=RUN 3=FLUSH
  int m_st, m_act, m_seg;
  bit m_sp, m_pf;
  int m_bpend, m_bsel;
  bit runq[$];

  function automatic int m_phase();
    return (m_st != 0) ? (m_act % SPS) : 0;
  endfunction
  function automatic bit m_stb();
    return (m_st != 0) && (m_phase() == SPS - 1);
  endfunction
  function automatic bit m_ack();
    return m_pf && ((m_st == 0) || m_stb());
  endfunction

  task automatic model_reset();
    m_st = 0; m_act = 0; m_seg = 0; m_sp = 0; m_pf = 0; m_bpend = 0; m_bsel = 0;
    runq.delete();
  endtask

  task automatic model_step();
    bit stb, ack, seg_done;
    stb = m_stb();
    ack = m_ack();
    seg_done = stb && (m_act - m_seg + 1 == SEG);
    runq.push_back(m_st == 2);
    if (ack) m_bsel = m_bpend;
    if (bank_req) begin m_bpend = int'(bank_id); m_pf = 1; end
    else if (ack) m_pf = 0;
    case (m_st)
      0: if (start && !stop) begin m_st = 1; m_act = 0; m_seg = 0; end
      1: begin
        if (stop) m_sp = 1;
        if (seg_done) begin m_st = m_sp ? 3 : 2; m_sp = 0; m_seg = m_act + 1; end
        m_act++;
      end
      2: begin
        if (stb && (m_sp || stop)) begin m_st = 3; m_sp = 0; m_seg = m_act + 1; end
        else if (stop) m_sp = 1;
        m_act++;
      end
      default: begin
        if (seg_done) begin m_st = 0; m_act = 0; end
        else m_act++;
      end
    endcase
  endtask

  task automatic check_all();
    int ph;
    bit ov;
    ph = m_phase();
    ov = (runq.size() >= PIPE_LAT) ? runq[runq.size() - PIPE_LAT] : 1'b0;
    chk("state", 32'(state), 32'(m_st));
    chk("phase", 32'(phase), 32'(ph));
    chk("busy", 32'(busy), 32'(m_st != 0));
    chk("sym_stb", 32'(sym_stb), 32'(m_stb()));
    chk("iq_sel", 32'(iq_sel), 32'(ph % 2));
    chk("mix_neg", 32'(mix_neg), 32'((m_st != 0) && ((ph / 2) % 2 == 0)));
    chk("data_en", 32'(data_en), 32'(m_st == 1 || m_st == 2));
    chk("out_valid", 32'(out_valid), 32'(ov));
    chk("bank_sel", 32'(bank_sel), 32'(m_bsel));
    chk("bank_ack", 32'(bank_ack), 32'(m_ack()));
  endtask

  task automatic cyc(input logic s, input logic p, input logic r, input int id);
    start = s; stop = p; bank_req = r; bank_id = BANK_W'(id);
    @(negedge clock_5000);
    check_all();
    @(posedge clock_5000);
    model_step();
    #1;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0);
  endtask

  task automatic run_to_phase(input int p);
    for (int i = 0; i < SPS && m_phase() != p; i++) cyc(0, 0, 0, 0);
    chk("reach_phase", 32'(m_phase()), 32'(p));
  endtask

  task automatic run_to_state(input int s, input int budget);
    for (int i = 0; i < budget && m_st != s; i++) cyc(0, 0, 0, 0);
    chk("reach_state", 32'(state), 32'(s));
  endtask

  // Reset asserted mid-cycle; outputs must clear without waiting for an edge.
  task automatic do_reset();
    reset = 0; start = 0; stop = 0; bank_req = 0; bank_id = '0;
    #2;
    model_reset();
    check_all();
    @(negedge clock_5000);
    check_all();
    reset = 1;
    @(posedge clock_5000);
    model_step();
    #1;
  endtask

  initial begin
    int sent_fill_cycle;
    reset = 0; start = 0; stop = 0; bank_req = 0; bank_id = '0;
    model_reset();
    #1;
    do_reset();

    // Fill and run: start at cycle 0, RUN at 137, out_valid from 140
    cyc(1, 0, 0, 0);
    sent_fill_cycle = 0;
    for (int c = 1; c <= 141; c++) begin
      if (c == 1)   chk("fill_at_1", 32'(state), 32'd1);
      if (c == 8)   chk("first_stb", 32'(sym_stb), 32'd1);
      if (c == 136) chk("last_fill_stb", 32'(sym_stb), 32'd1);
      if (c == 137) chk("run_at_137", 32'(state), 32'd2);
      if (c == 139) chk("ov_low_139", 32'(out_valid), 32'd0);
      if (c == 140) chk("ov_high_140", 32'(out_valid), 32'd1);
      cyc(0, 0, 0, 0);
    end

    // Bank switch with overwrite, then request at phase 7
    run_to_phase(2); cyc(0, 0, 1, 1);
    run_to_phase(4); cyc(0, 0, 1, 0);
    idle_cycles(12);
    run_to_phase(2); cyc(0, 0, 1, 1);
    idle_cycles(4);
    run_to_phase(7); cyc(0, 0, 1, 0);
    idle_cycles(20);

    // Stop at phase 3, then full flush back to IDLE
    run_to_phase(3); cyc(0, 1, 0, 0);
    run_to_state(0, SEG + 2 * SPS);
    chk("idle_phase", 32'(phase), 32'd0);
    idle_cycles(5);

    // Start/stop collision in IDLE, and a bank request applied in IDLE
    for (int i = 0; i < 4; i++) cyc(1, 1, 0, 0);
    chk("collide_busy", 32'(busy), 32'd0);
    cyc(0, 0, 1, 1);
    idle_cycles(3);

    // Stop during FILL at symbol 5: RUN never entered
    cyc(1, 0, 0, 0);
    for (int i = 0; i < 5 * SPS + 2; i++) cyc(0, 0, 0, 0);
    cyc(0, 1, 0, 0);
    run_to_state(3, SEG);
    run_to_state(0, SEG + SPS);

    // Reset mid-RUN, then normal restart
    cyc(1, 0, 0, 0);
    run_to_state(2, SEG + SPS);
    idle_cycles(21);
    cyc(0, 0, 1, 1);
    do_reset();
    cyc(1, 0, 0, 0);
    run_to_state(2, SEG + SPS);
    idle_cycles(10);

    // Randomized traffic
    for (int i = 0; i < 12000; i++) begin
      if ($urandom_range(0, 2999) == 0) do_reset();
      else cyc($urandom_range(0, 39) == 0, $urandom_range(0, 249) == 0,
               $urandom_range(0, 24) == 0, int'($urandom_range(0, (1 << BANK_W) - 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
